// File: rtl/adder_bist.sv
// Built-in self test for a WIDTH-bit ripple-carry adder: LFSR operands out, {cout,sum} checked against a+b+cin.
// Define BIST_CIN_EN to drive the carry-in from the LFSR; otherwise cin_o is held at 0.
module adder_bist #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_VECTORS = 175,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_fail_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_next;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic               done_q, done_d, pass_q, pass_d;
    logic [15:0]        vec_q, vec_d, ffi_q, ffi_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WIDTH:0]     exp_sum;
    logic               mismatch;

    // Galois, right shift: feedback taps applied when the bit shifted out is 1
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign exp_sum   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign mismatch  = {cout_i, sum_i} != exp_sum;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        done_d  = done_q;
        pass_d  = pass_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_d  = SEED;
                    vec_d   = '0;
                    err_d   = '0;
                    ffi_d   = 16'hFFFF;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                a_d = lfsr_q[WIDTH-1:0];
                b_d = lfsr_q[2*WIDTH-1:WIDTH];
`ifdef BIST_CIN_EN
                cin_d = lfsr_q[15];
`else
                cin_d = 1'b0;
`endif
                lfsr_d  = lfsr_next;
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}})
                        err_d = err_q + 1'b1;
                    // err_count never decreases within a run, so zero means no earlier failure
                    if (err_q == '0)
                        ffi_d = vec_q;
                end
                vec_d = vec_q + 16'd1;
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            ffi_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
        end
    end

    assign a_o            = a_q;
    assign b_o            = b_q;
    assign cin_o          = cin_q;
    assign busy           = (state_q == DRIVE) || (state_q == CHECK);
    assign done           = done_q;
    assign pass           = pass_q;
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: operand-table reference model checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_adder_bist;
    localparam int W = 4;
    localparam int N = 175;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset, start;
    logic [W-1:0] a_o, b_o, sum_i;
    logic cin_o, cout_i, busy, done, pass;
    logic [15:0] vec_count, first_fail_idx;
    logic [15:0] err_count;

    logic [W-1:0] a4, b4, sum4;
    logic c4, cout4, busy4, done4, pass4;
    logic [15:0] vec4, ffi4;
    logic [3:0] err4;

    int mode;                 // 0 good, 1 inverted, 2 cout stuck 0, 3 random faults
    logic [511:0] fault_tab;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    int ecnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W:0] resp(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int md, input logic flt);
        logic [W:0] ex;
        ex = add_ref(a, b, c);
        case (md)
            1: return ~ex;
            2: return {1'b0, ex[W-1:0]};
            3: return flt ? (ex ^ 5'd1) : ex;
            default: return ex;
        endcase
    endfunction

    assign {cout_i, sum_i} = resp(a_o, b_o, cin_o, mode, fault_tab[{cin_o, b_o, a_o}]);
    assign {cout4, sum4}   = resp(a4, b4, c4, 1, 1'b0);

    adder_bist dut (
        .clk(clk), .reset(reset), .start(start),
        .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .sum_i(sum_i), .cout_i(cout_i),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .first_fail_idx(first_fail_idx)
    );

    adder_bist #(.ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start),
        .a_o(a4), .b_o(b4), .cin_o(c4), .sum_i(sum4), .cout_i(cout4),
        .busy(busy4), .done(done4), .pass(pass4), .vec_count(vec4),
        .err_count(err4), .first_fail_idx(ffi4)
    );

    // Operand table: vector k uses the LFSR state after k steps from SEED.
    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];
    logic         vc [N];
    bit           mm [N];

    // Run-level model: time since the accepted start edge decides everything.
    bit m_run;
    int m_t;
    logic [W-1:0] m_ha, m_hb;
    logic m_hc;

    logic [W-1:0] e_a, e_b;
    logic e_c, e_busy, e_done, e_pass;
    int e_vec, e_err;
    logic [15:0] e_ff;

    always_comb begin
        e_a = '0; e_b = '0; e_c = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
        e_vec = 0; e_err = 0; e_ff = 16'hFFFF;
        if (m_run) begin
            e_vec  = m_t / 2;
            e_busy = (m_t < 2 * N);
            e_done = !e_busy;
            if (m_t == 0) begin
                e_a = m_ha; e_b = m_hb; e_c = m_hc;
            end else begin
                e_a = va[(m_t - 1) / 2]; e_b = vb[(m_t - 1) / 2]; e_c = vc[(m_t - 1) / 2];
            end
            for (int k = 0; k < N; k++) begin
                if (k < e_vec && mm[k]) begin
                    if (e_err == 0) e_ff = 16'(k);
                    e_err = e_err + 1;
                end
            end
            e_pass = e_done && (e_err == 0);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_run <= 1'b0; m_t <= 0; m_ha <= '0; m_hb <= '0; m_hc <= 1'b0;
        end else if (start && (!m_run || m_t >= 2 * N)) begin
            m_run <= 1'b1; m_t <= 0; m_ha <= e_a; m_hb <= e_b; m_hc <= e_c;
            for (int k = 0; k < N; k++)
                mm[k] <= resp(va[k], vb[k], vc[k], mode, fault_tab[{vc[k], vb[k], va[k]}])
                         != add_ref(va[k], vb[k], vc[k]);
        end else if (m_run && m_t < 2 * N) begin
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pass", pass, e_pass);
            chk("vec_count", vec_count, e_vec);
            chk("err_count", err_count, e_err);
            chk("first_fail_idx", first_fail_idx, e_ff);
            chk("a_o", a_o, e_a);
            chk("b_o", b_o, e_b);
            chk("cin_o", cin_o, e_c);
        end
    end

    int s_edge;

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; s_edge = ecnt;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: done never rose within 1000 cycles", nm);
        end
    endtask

    task automatic new_faults();
        for (int i = 0; i < 512; i++) fault_tab[i] = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        logic [15:0] l;
        int ref_cnt;
        l = SEED;
        for (int k = 0; k < N; k++) begin
            va[k] = l[W-1:0];
            vb[k] = l[2*W-1:W];
`ifdef BIST_CIN_EN
            vc[k] = l[15];
`else
            vc[k] = 1'b0;
`endif
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
        // Pin the operand table to hand-stepped LFSR values (ACE1 -> E270).
        chk("va0", va[0], 4'h1);
        chk("vb0", vb[0], 4'hE);
        chk("va1", va[1], 4'h0);
        chk("vb1", vb[1], 4'h7);
`ifdef BIST_CIN_EN
        chk("vc0", vc[0], 1'b1);
`else
        chk("vc0", vc[0], 1'b0);
`endif

        mode = 0; fault_tab = '0;
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1; chk_en = 1;
        @(negedge clk); reset = 1'b0;
        chk("rst_a_o", a_o, 0);
        chk("rst_ffi", first_fail_idx, 16'hFFFF);
        chk("rst_busy", busy, 0);

        // Good adder.
        pulse_start();
        wait_done("run_good");
        chk("good_lat", ecnt - s_edge, 2 * N);
        chk("good_pass", pass, 1);
        chk("good_vec", vec_count, N);
        chk("good_err", err_count, 0);
        chk("good_ffi", first_fail_idx, 16'hFFFF);
        chk("good_last_a", a_o, va[N-1]);

        // Inverted adder, restarted from DONE.
        mode = 1;
        pulse_start();
        wait_done("run_inv");
        chk("inv_err", err_count, N);
        chk("inv_pass", pass, 0);
        chk("inv_ffi", first_fail_idx, 0);
        chk("sat_err4", err4, 4'hF);
        chk("sat_vec4", vec4, N);

        // Random faults; start held high for 20 cycles mid-run.
        mode = 3; new_faults();
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_done("run_hold");
        chk("hold_lat", ecnt - s_edge, 2 * N);

        // Reset mid-run at vec_count 50.
        mode = 0;
        pulse_start();
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (vec_count == 16'd50) begin hit = 1; break; end
            end
            chk("reach_vec50", hit, 1);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_vec", vec_count, 0);
        chk("mid_a", a_o, 0);
        chk("mid_ffi", first_fail_idx, 16'hFFFF);
        repeat (3) @(negedge clk);

        // Carry-out stuck at 0.
        mode = 2;
        ref_cnt = 0;
        for (int k = 0; k < N; k++) begin
            logic [W:0] s;
            s = add_ref(va[k], vb[k], vc[k]);
            if (s[W]) ref_cnt++;
        end
        pulse_start();
        wait_done("run_stuck");
        chk("stuck_err", err_count, ref_cnt);

        // Random fault tables with random start noise while running.
        for (int r = 0; r < 2; r++) begin
            mode = 3; new_faults();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse_start();
            while (vec_count < 16'd150 && busy) begin
                start = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            start = 1'b0;
            wait_done("run_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
